// File: rtl/timing_sequencer.sv
// timing_sequencer: parametrised T-state generator with memory wait-state
// insertion (bounded by WAIT_LIMIT), a halt/resume state machine and a
// synchronous clear.
// Optional build macro TIMING_SEQ_SINGLE_STEP_EN adds step_mode/step ports:
// with step_mode=1 the wrap from T[NUM_T-1] enters HALT, and step resumes
// for one full instruction.
module timing_sequencer #(
    parameter int NUM_T      = 8,
    parameter int CNT_WIDTH  = 3,
    parameter int WAIT_LIMIT = 15
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 hlt_req,
    input  logic                 clr_timer,
    input  logic                 wait_en,
    input  logic                 mem_ready,
    input  logic                 resume,
`ifdef TIMING_SEQ_SINGLE_STEP_EN
    input  logic                 step_mode,
    input  logic                 step,
`endif
    output logic [NUM_T-1:0]     T,
    output logic [CNT_WIDTH-1:0] t_idx,
    output logic                 stalled,
    output logic                 halted,
    output logic                 wait_timeout
);

    typedef enum logic [1:0] {BOOT, RUN, WAIT, HALT} state_t;

    localparam logic [CNT_WIDTH-1:0] LAST_IDX = CNT_WIDTH'(NUM_T - 1);
    localparam logic [NUM_T-1:0]     T_ONE    = NUM_T'(1);
    localparam logic [7:0]           LIMIT    = 8'(WAIT_LIMIT);

    state_t                 state;
    logic [7:0]             wait_cnt;

    logic                   at_last;
    logic                   wrap_halt;
    logic                   go;
    logic [CNT_WIDTH-1:0]   nxt_idx;
    logic                   exit_halt;
    logic [CNT_WIDTH-1:0]   exit_idx;
    logic [NUM_T-1:0]       exit_t;

    // Target of a normal step out of RUN or WAIT: halt > clear > advance/wrap.
    // Shared by both states so a deferred halt/clear behaves exactly as in RUN.
    always_comb begin
        at_last = (t_idx == LAST_IDX);
        nxt_idx = at_last ? '0 : t_idx + 1'b1;
`ifdef TIMING_SEQ_SINGLE_STEP_EN
        wrap_halt = step_mode & at_last;
        go        = resume | step;
`else
        wrap_halt = 1'b0;
        go        = resume;
`endif
        exit_halt = hlt_req | (~clr_timer & wrap_halt);
        exit_idx  = (hlt_req | clr_timer | wrap_halt) ? '0 : nxt_idx;
        exit_t    = exit_halt ? '0 : (T_ONE << exit_idx);
    end

    // Sequencer state machine with all outputs registered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= BOOT;
            T            <= '0;
            t_idx        <= '0;
            stalled      <= 1'b0;
            halted       <= 1'b0;
            wait_timeout <= 1'b0;
            wait_cnt     <= '0;
        end else begin
            wait_timeout <= 1'b0;
            case (state)
                BOOT: begin
                    state <= RUN;
                    t_idx <= '0;
                    T     <= T_ONE;
                end
                RUN: begin
                    if (!hlt_req && !clr_timer && wait_en && !mem_ready) begin
                        state    <= WAIT;
                        stalled  <= 1'b1;
                        wait_cnt <= 8'd1;
                    end else begin
                        state  <= exit_halt ? HALT : RUN;
                        halted <= exit_halt;
                        t_idx  <= exit_idx;
                        T      <= exit_t;
                    end
                end
                WAIT: begin
                    if (mem_ready || wait_cnt >= LIMIT) begin
                        stalled      <= 1'b0;
                        wait_cnt     <= '0;
                        wait_timeout <= ~mem_ready;
                        state        <= exit_halt ? HALT : RUN;
                        halted       <= exit_halt;
                        t_idx        <= exit_idx;
                        T            <= exit_t;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                HALT: begin
                    if (go) begin
                        state  <= RUN;
                        halted <= 1'b0;
                        t_idx  <= '0;
                        T      <= T_ONE;
                    end
                end
                default: begin
                    state <= BOOT;
                end
            endcase
        end
    end

endmodule
